// File: rtl/fetch_pkg.sv
// Shared types for the decoupled instruction fetch front end.
package fetch_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc_add4;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fq_fifo.sv
// Circular buffer for fetched entries: push, pop, clear (clear wins) and occupancy count.
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != FULL);
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupled fetch: credit-limited in-order imem requests, response FIFO, redirect/flush FSM.
// Define IFQ_BYPASS_EN to present a response to an empty queue in the same cycle.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = $clog2(DEPTH+1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_add4_o,
  output logic [CNT_W-1:0]   count_o
);
  localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, entry_pc_q, entry_pc_d, tgt_pc;
  logic [CNT_W-1:0] outst_q, outst_d, occ;
  logic [CNT_W:0]  inflight;
  logic            gnt_fire, rsp_keep, byp_vld, pop, fifo_empty;
  fq_entry_t       rsp_e, fifo_head, head_e;

  assign tgt_pc   = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign inflight = {1'b0, occ} + {1'b0, outst_q};

  assign imem_req_o  = (state_q == RUN) && !redirect_i && (inflight < CREDITS);
  assign imem_addr_o = (state_q == RUN) ? fetch_pc_q : '0;
  assign gnt_fire    = imem_req_o && imem_gnt_i;

  // Responses are only kept in RUN; redirect discards same-cycle data.
  assign rsp_keep = (state_q == RUN) && imem_rvalid_i && !redirect_i;
  assign rsp_e    = '{pc_add4: entry_pc_q + 32'd4, instr: imem_rdata_i};

`ifdef IFQ_BYPASS_EN
  assign byp_vld = rsp_keep && fifo_empty;
`else
  assign byp_vld = 1'b0;
`endif

  assign head_e        = fifo_empty ? rsp_e : fifo_head;
  assign instr_valid_o = !fifo_empty || byp_vld;
  assign instr_o       = instr_valid_o ? head_e.instr   : NOP_INSTR;
  assign pc_add4_o     = instr_valid_o ? head_e.pc_add4 : '0;
  assign pop           = instr_valid_o && !stall_i && !redirect_i;

  fq_fifo #(.DEPTH(DEPTH), .W($bits(fq_entry_t)), .CNT_W(CNT_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (redirect_i),
    .push_i  (rsp_keep && !(byp_vld && pop)),
    .pop_i   (pop && !fifo_empty),
    .data_i  (rsp_e),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (occ)
  );
  assign count_o = occ;

  always_comb begin
    state_d    = state_q;
    outst_d    = outst_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid_i);
    fetch_pc_d = gnt_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    entry_pc_d = rsp_keep ? entry_pc_q + 32'd4 : entry_pc_q;
    if (redirect_i) begin
      fetch_pc_d = tgt_pc;
      entry_pc_d = tgt_pc;
      state_d    = (state_q == FLUSH || outst_d != '0) ? FLUSH : RUN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   if (outst_d == '0) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      entry_pc_q <= RESET_PC;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      entry_pc_q <= entry_pc_d;
      outst_q    <= outst_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: in-order memory model plus an architectural fetch-stream scoreboard.
module tb_instr_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int FIRST_V = BYP ? 2 : 3;

  logic clk = 1'b0;
  logic rst_i, stall_i, redirect_i, imem_gnt_i, imem_rvalid_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, pc_add4_o;
  logic [CNT_W-1:0] count_o;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_add4_o(pc_add4_o), .count_o(count_o)
  );

  typedef struct {logic [31:0] addr; int due; bit live;} pend_t;
  pend_t       pend[$];
  fq_entry_t   expq[$];
  logic [31:0] glog[$];
  int          cyc, lat, occ_m, vecs, errs;
  bit          gnt_en;
  logic [31:0] exp_fetch;
  logic        s_req, s_valid, s_rv;
  logic [31:0] s_addr, s_instr, s_pc4;
  logic [CNT_W-1:0] s_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // One clock: drive memory, sample, check against the stream model, advance.
  task automatic step();
    bit live_rv, has_dead, exp_v, pop;
    pend_t p;
    imem_gnt_i = gnt_en; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    live_rv = 1'b0; has_dead = 1'b0;
    if (rst_i) pend.delete();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(p.addr);
      live_rv = p.live && !redirect_i;
      has_dead = !p.live;
    end
    foreach (pend[i]) if (!pend[i].live) has_dead = 1'b1;
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o;
    s_instr = instr_o; s_pc4 = pc_add4_o; s_cnt = count_o; s_rv = imem_rvalid_i;
    if (!rst_i) begin
      exp_v = (occ_m > 0) || (BYP && live_rv);
      vecs++; if (s_valid !== exp_v) begin errs++; $display("FAIL valid cyc=%0d got %b exp %b", cyc, s_valid, exp_v); end
      vecs++; if (s_cnt !== occ_m[CNT_W-1:0]) begin errs++; $display("FAIL count cyc=%0d got %0d exp %0d", cyc, s_cnt, occ_m); end
      vecs++; if (s_cnt > DEPTH) begin errs++; $display("FAIL overflow cyc=%0d got %0d max %0d", cyc, s_cnt, DEPTH); end
      if (redirect_i || has_dead) begin
        vecs++; if (s_req !== 1'b0) begin errs++; $display("FAIL req_in_flush cyc=%0d got %b exp 0", cyc, s_req); end
      end
      if (exp_v) begin
        vecs++;
        if (expq.size() == 0) begin errs++; $display("FAIL head cyc=%0d got %h/%h exp none", cyc, s_pc4, s_instr); end
        else if ({s_pc4, s_instr} !== expq[0]) begin
          errs++; $display("FAIL head cyc=%0d got %h/%h exp %h/%h", cyc, s_pc4, s_instr, expq[0].pc_add4, expq[0].instr);
        end
      end else begin
        vecs++; if (s_instr !== 32'h0 || s_pc4 !== 32'h0) begin errs++; $display("FAIL nop cyc=%0d got %h/%h exp 0/0", cyc, s_pc4, s_instr); end
      end
      pop = exp_v && !stall_i && !redirect_i;
      if (s_req && imem_gnt_i) begin
        vecs++; if (s_addr !== exp_fetch) begin errs++; $display("FAIL fetch_addr cyc=%0d got %h exp %h", cyc, s_addr, exp_fetch); end
        glog.push_back(s_addr);
        pend.push_back('{s_addr, cyc + lat, 1'b1});
        expq.push_back({exp_fetch + 32'd4, mem_word(exp_fetch)});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redirect_i) begin
        expq.delete(); occ_m = 0; exp_fetch = {redirect_pc_i[31:2], 2'b00};
        foreach (pend[i]) pend[i].live = 1'b0;
      end else begin
        if (pop && expq.size() > 0) void'(expq.pop_front());
        occ_m = occ_m + int'(live_rv) - int'(pop);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    step(); step();
    rst_i = 1'b0;
    pend.delete(); expq.delete(); glog.delete();
    occ_m = 0; exp_fetch = 32'h0; cyc = 0;
  endtask

  task automatic test_reset();
    lat = 1; gnt_en = 1'b1;
    do_reset();
    vecs++; if (s_req !== 1'b0)      begin errs++; $display("FAIL rst_req got %b exp 0", s_req); end
    vecs++; if (s_addr !== 32'h0)    begin errs++; $display("FAIL rst_addr got %h exp 0", s_addr); end
    vecs++; if (s_valid !== 1'b0)    begin errs++; $display("FAIL rst_valid got %b exp 0", s_valid); end
    vecs++; if (s_instr !== 32'h0)   begin errs++; $display("FAIL rst_instr got %h exp 0", s_instr); end
    vecs++; if (s_pc4 !== 32'h0)     begin errs++; $display("FAIL rst_pc4 got %h exp 0", s_pc4); end
    vecs++; if (s_cnt !== '0)        begin errs++; $display("FAIL rst_count got %0d exp 0", s_cnt); end
  endtask

  task automatic test_stream();
    int first = -1;
    lat = 1; gnt_en = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_valid && first < 0) begin
        first = i;
        vecs++; if (s_pc4 !== 32'h4) begin errs++; $display("FAIL first_pc4 got %h exp 4", s_pc4); end
      end else if (first >= 0) begin
        vecs++; if (s_valid !== 1'b1) begin errs++; $display("FAIL stream_gap cyc=%0d got 0 exp 1", i); end
      end
    end
    vecs++; if (first != FIRST_V) begin errs++; $display("FAIL first_valid_cyc got %0d exp %0d", first, FIRST_V); end
    vecs++;
    if (glog.size() < 4) begin errs++; $display("FAIL addr_seq got %0d grants exp >=4", glog.size()); end
    else for (int k = 0; k < 4; k++)
      if (glog[k] !== 32'(4*k)) begin errs++; $display("FAIL addr_seq[%0d] got %h exp %h", k, glog[k], 32'(4*k)); end
  endtask

  task automatic test_stall();
    lat = 2; gnt_en = 1'b1;
    do_reset();
    step(); step();
    stall_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    vecs++; if (s_cnt !== 3'(DEPTH)) begin errs++; $display("FAIL stall_full got %0d exp %0d", s_cnt, DEPTH); end
    vecs++; if (s_req !== 1'b0) begin errs++; $display("FAIL stall_req got %b exp 0", s_req); end
    vecs++; if (s_pc4 !== 32'h4) begin errs++; $display("FAIL stall_head got %h exp 4", s_pc4); end
    stall_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_redirect();
    int first = -1;
    lat = 3; gnt_en = 1'b1;
    do_reset();
    step(); step(); step();
    vecs++; if (pend.size() != 2) begin errs++; $display("FAIL redir_outst got %0d exp 2", pend.size()); end
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step();
    vecs++; if (s_req !== 1'b0) begin errs++; $display("FAIL redir_req got %b exp 0", s_req); end
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++; if (s_rv !== 1'b1 || s_cnt !== '0) begin errs++; $display("FAIL flush_drop got rv=%b cnt=%0d exp rv=1 cnt=0", s_rv, s_cnt); end
    end
    step();
    vecs++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin errs++; $display("FAIL refetch got req=%b addr=%h exp 1/40", s_req, s_addr); end
    for (int i = 0; i < 8 && first < 0; i++) begin
      step();
      if (s_valid) first = i;
    end
    vecs++; if (first < 0 || s_pc4 !== 32'h44) begin errs++; $display("FAIL redir_head got %h exp 44", s_pc4); end
  endtask

  task automatic test_align_wrap();
    lat = 1; gnt_en = 1'b1;
    do_reset();
    step(); step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h43; glog.delete();
    step(); redirect_i = 1'b0;
    for (int i = 0; i < 6 && glog.size() == 0; i++) step();
    vecs++; if (glog.size() == 0 || glog[0] !== 32'h40) begin errs++; $display("FAIL align got %h exp 40", glog.size() ? glog[0] : 32'hx); end
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; glog.delete();
    step(); redirect_i = 1'b0;
    for (int i = 0; i < 8 && glog.size() < 2; i++) step();
    vecs++;
    if (glog.size() < 2) begin errs++; $display("FAIL wrap got %0d grants exp 2", glog.size()); end
    else if (glog[0] !== 32'hFFFF_FFFC || glog[1] !== 32'h0) begin
      errs++; $display("FAIL wrap got %h,%h exp fffffffc,0", glog[0], glog[1]);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_gnt_hold();
    lat = 2; gnt_en = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errs++; $display("FAIL gnt_hold got req=%b addr=%h exp 1/0", s_req, s_addr); end
    end
    gnt_en = 1'b1; step();
    gnt_en = 1'b0; step();
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    step();
    vecs++; if (s_rv !== 1'b1) begin errs++; $display("FAIL redir_rv got %b exp 1", s_rv); end
    redirect_i = 1'b0; gnt_en = 1'b1;
    step();
    vecs++; if (s_req !== 1'b1 || s_addr !== 32'h80 || s_cnt !== '0) begin
      errs++; $display("FAIL redir_rv_after got req=%b addr=%h cnt=%0d exp 1/80/0", s_req, s_addr, s_cnt);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_bypass();
    lat = 1; gnt_en = 1'b1;
    do_reset();
    step(); step(); step();
    vecs++; if (s_rv !== 1'b1 || s_valid !== BYP) begin errs++; $display("FAIL byp_t got rv=%b valid=%b exp 1/%b", s_rv, s_valid, BYP); end
    vecs++; if (s_cnt !== '0) begin errs++; $display("FAIL byp_cnt got %0d exp 0", s_cnt); end
    step();
    vecs++; if (s_valid !== 1'b1 || s_pc4 !== (BYP ? 32'h8 : 32'h4)) begin
      errs++; $display("FAIL byp_t1 got valid=%b pc4=%h exp 1/%h", s_valid, s_pc4, BYP ? 32'h8 : 32'h4);
    end
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    stall_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    vecs = 0; errs = 0; cyc = 0; occ_m = 0; exp_fetch = '0;
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_align_wrap();
    test_gnt_hold();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Decoupled instruction fetch front end. Sits directly upstream of the IF/ID pipeline register and replaces the bare PC register, PC+4 adder and zero-latency instruction memory lookup.
- Issues in-order requests to a variable-latency instruction memory over a request/grant and response handshake. Buffers returned words in a small FIFO.
- Presents {pc_add4, instr} to IF/ID with a valid bit. Honours hazard stalls (hold) and branch redirects (flush and refetch).

Parameters:
- DEPTH, 4, number of queue entries (power of two, at least 2).
- RESET_PC, 32'h0000_0000, fetch address after reset.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and outstanding counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- stall_i  in  1  hazard hold from the hazard detection unit (inverse of pcWrite); the head entry is not consumed.
- redirect_i  in  1  taken branch resolved in MEM (PCSrc).
- redirect_pc_i  in  32  branch target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after the grant.
- imem_rdata_i  in  32  response instruction word.
- instr_valid_o  out  1  the head entry is valid.
- instr_o  out  32  head instruction; 32'h0 (NOP) when not valid.
- pc_add4_o  out  32  head PC+4; 0 when not valid.
- count_o  out  CNT_W  current queue occupancy.

Behaviour:
- Reset (rst_i high at a clock edge):
  - fetch_pc = RESET_PC; occupancy = 0; outstanding = 0; state = IDLE.
  - All outputs are 0.
  - The memory shares rst_i, so no stale responses arrive after reset.
- FSM states:
  - IDLE: no requests. Moves to RUN after 1 cycle.
  - RUN: normal fetching.
  - FLUSH: no requests; responses are discarded. Moves to RUN the cycle after outstanding reaches 0, or immediately if it is already 0 when the redirect is taken.
- Issue rule (RUN only):
  - imem_req_o = 1 while occupancy + outstanding < DEPTH.
  - imem_addr_o = fetch_pc.
  - Address and request are held stable until imem_gnt_i.
  - On grant: fetch_pc += 4 (modulo 2^32, wraps), outstanding += 1.
- Response handling:
  - In RUN, imem_rvalid_i pushes {entry_pc+4, imem_rdata_i}. entry_pc is tracked as a second PC pointer advanced per response.
  - In FLUSH, the response is dropped.
  - Either way, outstanding -= 1.
  - Overflow is impossible by the credit rule; the bench asserts this.
- Pop:
  - Occurs when instr_valid_o && !stall_i && !redirect_i; the head advances.
  - Push and pop in the same cycle leave occupancy unchanged.
- Redirect (highest priority):
  - Queue is cleared and any pop that cycle is ignored.
  - fetch_pc and entry_pc = {redirect_pc_i[31:2], 2'b00}.
  - Any response or grant in the same cycle counts toward outstanding but its data is discarded.
  - Next state: FLUSH if outstanding after this cycle is > 0, else RUN.
  - A redirect arriving while in FLUSH updates the target and stays in FLUSH.
- imem_req_o is deasserted in the cycle a redirect is taken.
- Latency: grant → response (memory-defined) → head visible the cycle after the response (base build).
- Queue empty: instr_valid_o = 0 and the outputs are NOP/0, so IF/ID sees a bubble.
- Stall while empty: no effect.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined: in RUN with an empty queue, an imem_rvalid_i response is presented combinationally the same cycle (instr_valid_o = 1, instr_o = imem_rdata_i).
  - If it is popped that cycle, it is not written into the queue.
  - If stall_i is high, it is written as normal.
- When undefined: head outputs come only from queue storage; minimum response-to-output latency is 1 cycle.

Decomposition:
- Package fetch_pkg holds:
  - PC_W = 32, INSTR_W = 32, NOP_INSTR = 32'h0.
  - fetch_state_t enum {IDLE, RUN, FLUSH}.
  - A packed struct fq_entry_t {pc_add4, instr}.
- One sub-module, fq_fifo: circular buffer with push, pop, clear and count, parameterised by DEPTH and entry width. The FSM, credit logic and PC pointers live in the top.

Test Plan:
- Reset, memory with grant always high and 1-cycle response → imem_addr_o sequence 0x0, 0x4, 0x8, 0xC; first instr_valid_o 3 cycles after reset release with pc_add4_o = 0x4; then one instruction per cycle.
- stall_i held for 6 cycles with a 2-cycle memory → count_o saturates at 4, imem_req_o = 0 at full, head is stable, no overflow.
- redirect_i with redirect_pc_i = 0x40 while 2 requests are outstanding → next 2 responses dropped, state FLUSH for 2 cycles, next address 0x40, first valid pc_add4_o = 0x44.
- redirect_pc_i = 0x43 → fetch address 0x40. fetch_pc = 0xFFFF_FFFC → next address wraps to 0x0.
- Grant withheld for 3 cycles → imem_addr_o and imem_req_o stable throughout. Redirect and rvalid in the same cycle → response discarded, outstanding decremented.
- IFQ_BYPASS_EN defined, empty queue, response at cycle t → instr_valid_o = 1 at t, count_o stays 0. Same case undefined → valid at t+1.
